// File: rtl/program_loader_pkg.sv
// Shared constants for the boot-time program loader: FSM encodings and
// sizing helpers used by the top and the word assembler.
package program_loader_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_DLOAD = 3'd2;
    localparam logic [2:0] S_ILOAD = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    // Bytes per word (and per header) is 4, so a 2-bit index covers it.
    localparam int BYTE_IDX_W = 2;

    function automatic int max_words(input int addr_width);
        return 2 ** (addr_width - 2);
    endfunction

endpackage

// File: rtl/program_loader_word_asm.sv
// Packs a byte stream into little-endian 32-bit words; used for both the
// 4-byte header and the payload words.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_vld,
    output logic        byte_last,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [BYTE_IDX_W-1:0] idx;

    // High while the next accepted byte completes the current word.
    assign byte_last = &idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            idx        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_vld && byte_last;
            if (byte_vld) begin
                word <= {byte_in, word[31:8]};
                idx  <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream and writes data then instruction
// words into the BRAMs, holding the core stalled until the load completes.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            s_byte,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic                  d_bram_init_done,
    output logic                  cpu_run,
    output logic                  busy,
    output logic                  err
);

    localparam int MAX_WORDS = max_words(ADDR_WIDTH);
    localparam int CNT_W     = ADDR_WIDTH - 1;

    logic [2:0]       state;
    logic [CNT_W-1:0] wcnt, wcnt_inc, d_cnt, i_cnt;
    logic             accept, fin, asm_clear, byte_last, word_valid;
    logic [31:0]      asm_word, full_word;
    logic [15:0]      hdr_d, hdr_i;
    logic             hdr_over, last_d, last_i;
    logic             wr_d, wr_i, wr_last_d, wr_final;

    assign s_ready   = state inside {S_HDR, S_DLOAD, S_ILOAD};
    assign accept    = s_valid && s_ready;
    assign fin       = accept && byte_last;
    assign asm_clear = start && (state inside {S_IDLE, S_DONE, S_ERR});

    // The word as it will look once the byte on the bus is shifted in.
    assign full_word = {s_byte, asm_word[31:8]};
    assign hdr_d     = full_word[15:0];
    assign hdr_i     = full_word[31:16];
    assign hdr_over  = (hdr_d > 16'(MAX_WORDS)) || (hdr_i > 16'(MAX_WORDS));

    assign wcnt_inc  = wcnt + 1'b1;
    assign last_d    = (wcnt_inc == d_cnt);
    assign last_i    = (wcnt_inc == i_cnt);

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_in    (s_byte),
        .byte_vld   (accept),
        .byte_last  (byte_last),
        .word       (asm_word),
        .word_valid (word_valid)
    );

    assign d_w_enb = word_valid && wr_d;
    assign i_w_enb = word_valid && wr_i;
    assign d_w_dat = asm_word;
    assign i_w_dat = asm_word;
    assign busy    = s_ready || d_w_enb || i_w_enb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= S_IDLE;
            wcnt             <= '0;
            d_cnt            <= '0;
            i_cnt            <= '0;
            d_w_addr         <= '0;
            i_w_addr         <= '0;
            wr_d             <= 1'b0;
            wr_i             <= 1'b0;
            wr_last_d        <= 1'b0;
            wr_final         <= 1'b0;
            d_bram_init_done <= 1'b0;
            cpu_run          <= 1'b0;
            err              <= 1'b0;
        end else begin
            // Hand the data BRAM over only after its last write has landed.
            if (d_w_enb && wr_last_d)
                d_bram_init_done <= 1'b1;
            if ((d_w_enb || i_w_enb) && wr_final)
                cpu_run <= 1'b1;

            if (fin) begin
                wr_d <= (state == S_DLOAD);
                wr_i <= (state == S_ILOAD);
            end

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state            <= S_HDR;
                        wcnt             <= '0;
                        cpu_run          <= 1'b0;
                        d_bram_init_done <= 1'b0;
                        err              <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (fin) begin
                        d_cnt <= hdr_d[CNT_W-1:0];
                        i_cnt <= hdr_i[CNT_W-1:0];
                        wcnt  <= '0;
                        if (hdr_over) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end else if (hdr_d != '0) begin
                            state <= S_DLOAD;
                        end else begin
                            d_bram_init_done <= 1'b1;
                            if (hdr_i != '0) begin
                                state <= S_ILOAD;
                            end else begin
                                state   <= S_DONE;
                                cpu_run <= 1'b1;
                            end
                        end
                    end
                end
                S_DLOAD: begin
                    if (fin) begin
                        d_w_addr  <= {wcnt[CNT_W-2:0], 2'b00};
                        wr_last_d <= last_d;
                        wr_final  <= last_d && (i_cnt == '0);
                        if (last_d) begin
                            wcnt  <= '0;
                            state <= (i_cnt == '0) ? S_DONE : S_ILOAD;
                        end else if (wcnt != CNT_W'(MAX_WORDS)) begin
                            wcnt <= wcnt_inc;
                        end
                    end
                end
                S_ILOAD: begin
                    if (fin) begin
                        i_w_addr  <= {wcnt[CNT_W-2:0], 2'b00};
                        wr_last_d <= 1'b0;
                        wr_final  <= last_i;
                        if (last_i)
                            state <= S_DONE;
                        else if (wcnt != CNT_W'(MAX_WORDS))
                            wcnt <= wcnt_inc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a frame-level model predicts every
// output each cycle, plus literal checks on the directed scenarios.
module tb_program_loader;

    localparam int AW   = 10;
    localparam int MAXW = 256;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, s_valid = 1'b0;
    logic [7:0]    s_byte = '0;
    logic          s_ready, d_w_enb, i_w_enb, d_bram_init_done, cpu_run, busy, err;
    logic [AW-1:0] d_w_addr, i_w_addr;
    logic [31:0]   d_w_dat, i_w_dat;

    int   checks = 0, passes = 0;
    logic noise = 1'b0;
    logic [31:0] dq[$], iq[$];

    typedef struct { logic is_i; int addr; logic [31:0] data; } wr_t;
    wr_t wlog[$], nomlog[$];

    // Model: 0 idle, 1 loading, 2 done, 3 rejected
    int          m_mode = 0, m_nacc = 0, m_dc = 0, m_ic = 0, m_w = 0, m_waddr = 0;
    logic [31:0] m_sh = '0, m_wdata = '0;
    logic        m_wv = 0, m_wi = 0, m_wlastd = 0, m_wfinal = 0;
    logic        m_cpu = 0, m_init = 0, m_err = 0, pv, pfin, pld;

    always #5 clk = ~clk;

    program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .s_byte(s_byte), .s_valid(s_valid),
        .s_ready(s_ready), .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
        .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
        .d_bram_init_done(d_bram_init_done), .cpu_run(cpu_run), .busy(busy), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            m_mode = 0; m_nacc = 0; m_wv = 0; m_cpu = 0; m_init = 0; m_err = 0;
            chk("rst_flags", 32'({s_ready, d_w_enb, i_w_enb, d_bram_init_done, cpu_run, busy, err}), 32'd0);
            chk("rst_addr", 32'({d_w_addr, i_w_addr}), 32'd0);
            chk("rst_dat", d_w_dat | i_w_dat, 32'd0);
        end else begin
            chk("s_ready", 32'(s_ready), 32'(m_mode == 1));
            chk("busy", 32'(busy), 32'(m_mode == 1 || m_wv));
            chk("err", 32'(err), 32'(m_err));
            chk("cpu_run", 32'(cpu_run), 32'(m_cpu));
            chk("init_done", 32'(d_bram_init_done), 32'(m_init));
            chk("d_w_enb", 32'(d_w_enb), 32'(m_wv && !m_wi));
            chk("i_w_enb", 32'(i_w_enb), 32'(m_wv && m_wi));
            if (m_wv && !m_wi) begin
                chk("d_w_addr", 32'(d_w_addr), 32'(m_waddr));
                chk("d_w_dat", d_w_dat, m_wdata);
            end
            if (m_wv && m_wi) begin
                chk("i_w_addr", 32'(i_w_addr), 32'(m_waddr));
                chk("i_w_dat", i_w_dat, m_wdata);
            end
            if (d_w_enb) wlog.push_back('{1'b0, int'(d_w_addr), d_w_dat});
            if (i_w_enb) wlog.push_back('{1'b1, int'(i_w_addr), i_w_dat});

            // Advance with the inputs the next rising edge will sample.
            pv = m_wv; pfin = m_wfinal; pld = m_wlastd;
            m_wv = 1'b0;
            if (pv && pfin) m_cpu = 1'b1;
            if (pv && pld)  m_init = 1'b1;
            if (m_mode != 1) begin
                if (start) begin
                    m_mode = 1; m_nacc = 0; m_cpu = 0; m_init = 0; m_err = 0;
                end
            end else if (s_valid) begin
                m_sh = {s_byte, m_sh[31:8]};
                m_nacc++;
                if (m_nacc == 4) begin
                    m_dc = int'({16'd0, m_sh[15:0]});
                    m_ic = int'({16'd0, m_sh[31:16]});
                    if (m_dc > MAXW || m_ic > MAXW) begin
                        m_mode = 3; m_err = 1'b1;
                    end else if (m_dc == 0) begin
                        m_init = 1'b1;
                        if (m_ic == 0) begin m_mode = 2; m_cpu = 1'b1; end
                    end
                end else if (m_nacc > 4 && m_nacc % 4 == 0) begin
                    m_w      = (m_nacc - 4) / 4 - 1;
                    m_wv     = 1'b1;
                    m_wdata  = m_sh;
                    m_wi     = (m_w >= m_dc);
                    m_waddr  = 4 * (m_wi ? m_w - m_dc : m_w);
                    m_wlastd = (m_w == m_dc - 1);
                    m_wfinal = (m_w == m_dc + m_ic - 1);
                    if (m_wfinal) m_mode = 2;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gmax);
        int g;
        g = $urandom_range(gmax, 0);
        repeat (g) begin
            s_valid = 1'b0; s_byte = 8'($urandom); tick();
        end
        s_valid = 1'b1; s_byte = b;
        if (noise) start = ($urandom_range(7, 0) == 0);
        tick();
        start = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic send_body(input logic [15:0] hd, input logic [15:0] hi, input int gmax, input int limit);
        logic [7:0] bq[$];
        bq = '{hd[7:0], hd[15:8], hi[7:0], hi[15:8]};
        foreach (dq[k]) for (int b = 0; b < 4; b++) bq.push_back(dq[k][8*b +: 8]);
        foreach (iq[k]) for (int b = 0; b < 4; b++) bq.push_back(iq[k][8*b +: 8]);
        for (int k = 0; k < bq.size() && (limit < 0 || k < limit); k++) send_byte(bq[k], gmax);
        s_valid = 1'b0;
    endtask

    task automatic fill(input int nd, input int ni);
        dq.delete(); iq.delete();
        repeat (nd) dq.push_back($urandom);
        repeat (ni) iq.push_back($urandom);
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_cpu_run", 32'(cpu_run), 32'd0);
        chk("reset_s_ready", 32'(s_ready), 32'd0);
        rst = 1'b1;
        repeat (2) tick();
        chk("idle_s_ready", 32'(s_ready), 32'd0);

        // Nominal full-rate load
        dq = '{32'h0000002A, 32'h00000002, 32'hFFFFFFD6};
        iq.delete();
        repeat (11) iq.push_back($urandom);
        wlog.delete();
        start_pulse(); send_body(16'd3, 16'd11, 0, -1); idle(3);
        chk("nom_count", 32'(wlog.size()), 32'd14);
        if (wlog.size() == 14) begin
            chk("nom_d0_addr", 32'(wlog[0].addr), 32'h0);
            chk("nom_d0_dat", wlog[0].data, 32'h0000002A);
            chk("nom_d1_addr", 32'(wlog[1].addr), 32'h4);
            chk("nom_d1_dat", wlog[1].data, 32'h00000002);
            chk("nom_d2_addr", 32'(wlog[2].addr), 32'h8);
            chk("nom_d2_dat", wlog[2].data, 32'hFFFFFFD6);
            chk("nom_i0_port", 32'(wlog[3].is_i), 32'd1);
            chk("nom_i10_addr", 32'(wlog[13].addr), 32'h28);
            chk("nom_i10_dat", wlog[13].data, iq[10]);
        end
        chk("nom_cpu_run", 32'(cpu_run), 32'd1);
        nomlog = wlog;

        // Re-load from DONE, then the same frame with gapped valid
        wlog.delete();
        start_pulse();
        chk("reload_s_ready", 32'(s_ready), 32'd1);
        chk("reload_cpu_run", 32'(cpu_run), 32'd0);
        chk("reload_init", 32'(d_bram_init_done), 32'd0);
        send_body(16'd3, 16'd11, 5, -1); idle(3);
        chk("gap_count", 32'(wlog.size()), 32'(nomlog.size()));
        if (wlog.size() == nomlog.size())
            foreach (wlog[k]) begin
                chk("gap_addr", 32'(wlog[k].addr), 32'(nomlog[k].addr));
                chk("gap_dat", wlog[k].data, nomlog[k].data);
            end

        // Zero counts
        wlog.delete(); dq.delete(); iq.delete();
        start_pulse(); send_body(16'd0, 16'd0, 0, -1);
        chk("zero_cpu_run", 32'(cpu_run), 32'd1);
        chk("zero_init", 32'(d_bram_init_done), 32'd1);
        idle(3);
        chk("zero_writes", 32'(wlog.size()), 32'd0);

        // Overflow on d_cnt, ignored bytes, then overflow on i_cnt
        start_pulse(); send_body(16'd257, 16'd1, 0, -1); idle(2);
        repeat (3) send_byte(8'($urandom), 0);
        idle(2);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_s_ready", 32'(s_ready), 32'd0);
        chk("ovf_cpu_run", 32'(cpu_run), 32'd0);
        chk("ovf_writes", 32'(wlog.size()), 32'd0);
        start_pulse(); send_body(16'd4, 16'd300, 0, -1); idle(2);
        chk("ovf_i_err", 32'(err), 32'd1);

        // Recovery after rejection
        fill(2, 3); wlog.delete();
        start_pulse(); send_body(16'd2, 16'd3, 1, -1); idle(3);
        chk("recover_err", 32'(err), 32'd0);
        chk("recover_cpu_run", 32'(cpu_run), 32'd1);
        chk("recover_writes", 32'(wlog.size()), 32'd5);

        // Reset two bytes into data word 1
        fill(2, 1); wlog.delete();
        start_pulse(); send_body(16'd2, 16'd1, 0, 10);
        rst = 1'b0; #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        tick(); tick();
        rst = 1'b1; tick();
        chk("midrst_idle", 32'(s_ready), 32'd0);
        chk("midrst_partial", 32'(wlog.size()), 32'd1);
        wlog.delete();
        start_pulse(); send_body(16'd2, 16'd1, 0, -1); idle(3);
        chk("midrst_count", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            chk("midrst_addr0", 32'(wlog[0].addr), 32'd0);
            chk("midrst_dat0", wlog[0].data, dq[0]);
        end

        // Largest legal frame
        fill(MAXW, MAXW); wlog.delete();
        start_pulse(); send_body(16'(MAXW), 16'(MAXW), 0, -1); idle(3);
        chk("max_count", 32'(wlog.size()), 32'(2 * MAXW));
        if (wlog.size() == 2 * MAXW) begin
            chk("max_d_last", 32'(wlog[MAXW-1].addr), 32'h3FC);
            chk("max_i_last", 32'(wlog[2*MAXW-1].addr), 32'h3FC);
        end
        chk("max_cpu_run", 32'(cpu_run), 32'd1);

        // Random frames with gaps and stray start pulses
        noise = 1'b1;
        for (int r = 0; r < 8; r++) begin
            int nd, ni;
            nd = $urandom_range(6, 0);
            ni = $urandom_range(6, 0);
            fill(nd, ni); wlog.delete();
            start_pulse(); send_body(16'(nd), 16'(ni), 3, -1); idle(4);
            chk("rand_count", 32'(wlog.size()), 32'(nd + ni));
            chk("rand_cpu_run", 32'(cpu_run), 32'd1);
        end
        noise = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader for the rv32i single-cycle core. It accepts a framed byte stream over a valid/ready handshake, packs the bytes into little-endian 32-bit words, and writes them through the data BRAM and instruction BRAM write ports. Data is written first, then instructions. While loading, it holds the core stalled; when loading completes it hands data BRAM control to the core and releases the PC.

## Interface
- `ADDR_WIDTH`, default 10: BRAM byte-address width. Maximum words per memory is `MAX_WORDS = 2**(ADDR_WIDTH-2)` = 256.
- `DATA_WIDTH`, default 32: word width. Fixed at 32; other values are unsupported.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, asynchronous assert, active-low.
- `start` in 1: one-cycle pulse that begins a load. Honoured only in IDLE, DONE and ERR.
- `s_byte` in 8: stream byte.
- `s_valid` in 1: `s_byte` is valid.
- `s_ready` out 1: loader can accept a byte. A byte transfers when `s_valid && s_ready`.
- `d_w_addr` out `ADDR_WIDTH`: data BRAM write byte address.
- `d_w_dat` out 32: data BRAM write word.
- `d_w_enb` out 1: data BRAM write strobe, one cycle per word.
- `i_w_addr` out `ADDR_WIDTH`: instruction BRAM write byte address.
- `i_w_dat` out 32: instruction BRAM write word.
- `i_w_enb` out 1: instruction BRAM write strobe.
- `d_bram_init_done` out 1: data BRAM write mux now selects the core.
- `cpu_run` out 1: core may execute. Integration drives `pc_stall = ~cpu_run`, `i_r_enb = cpu_run`, `rd_enbl = cpu_run`.
- `busy` out 1: a load is in progress.
- `err` out 1: the frame was rejected.

## Operation
- Frame format, in order:
  - `d_cnt`: 2 bytes, little-endian.
  - `i_cnt`: 2 bytes, little-endian.
  - `d_cnt` data words, 4 bytes each, little-endian.
  - `i_cnt` instruction words, 4 bytes each, little-endian.
- States:
  - IDLE → HDR on `start`.
  - HDR: collect 4 header bytes, then check counts.
    - If `d_cnt > MAX_WORDS` or `i_cnt > MAX_WORDS` → ERR.
    - Else if `d_cnt != 0` → DLOAD.
    - Else if `i_cnt != 0` → ILOAD.
    - Else → DONE.
  - DLOAD: each completed word k writes `d_w_addr = 4*k`. After word `d_cnt-1` → ILOAD, or DONE if `i_cnt = 0`.
  - ILOAD: each completed word k writes `i_w_addr = 4*k`. After word `i_cnt-1` → DONE.
  - DONE: `cpu_run = 1`, `s_ready = 0`. `start` → HDR.
  - ERR: `err = 1`, `s_ready = 0`, core stays stalled. `start` → HDR.
- `start` received in DONE or ERR clears `cpu_run`, `d_bram_init_done` and `err` on the next edge.
- `d_bram_init_done` rises when DLOAD exits, or directly from HDR when `d_cnt = 0`. It stays high until reset or a re-`start`.
- `s_ready = 1` exactly in HDR, DLOAD and ILOAD. There is no backpressure between bytes; a stall on `s_valid` only pauses assembly.
- `busy = 1` in HDR, DLOAD and ILOAD, and during the final write-strobe cycle.
- Bytes arriving on `s_byte` while `s_ready = 0` are ignored.
- Reset mid-load: the partial word is discarded and the FSM returns to IDLE. BRAM contents are not cleared.
- `start` received during HDR, DLOAD or ILOAD is ignored.

## Timing
- Reset values:
  - All outputs are 0 and the state is IDLE.
  - `d_w_addr`, `i_w_addr`, `d_w_dat` and `i_w_dat` are all 0.
- Write latency: the write strobe is high for exactly one cycle, in the cycle after the edge that accepts the 4th byte of a word. Address and data are stable during that cycle.
- Sustained rate: one word per 4 accepted bytes. At full-rate streaming (one byte per cycle), strobes are 4 cycles apart.
- `cpu_run` rises on the edge after the last write strobe, or 1 cycle after the header completes when both counts are 0.
- `d_w_enb` and `i_w_enb` are never high in the same cycle.
- Word counters saturate at `MAX_WORDS`. Addresses never wrap.

## Structure
- State encodings, the header length (4) and `MAX_WORDS` go in a shared include, `rv32i_loader.vh`, next to `rv32i_params.vh`.
- Sub-module `word_assembler`:
  - Behaviour: 2-bit byte index plus a 32-bit shift register.
  - Outputs: `word` and a one-cycle `word_valid`.
  - Inputs: a synchronous `clear`, driven on `start`.
  - Reused for the 4 header bytes.

## Test plan
- Nominal load:
  - Stimulus: frame `03 00 0B 00`, then data words `0000002A`, `00000002`, `FFFFFFD6` (sent `2A 00 00 00` …), then 11 instruction words, streamed at full rate.
  - Required: `d_w_enb` strobes at addresses 0x000, 0x004, 0x008 with those data values; 11 `i_w_enb` strobes at 0x000–0x028; `cpu_run` rises 1 cycle after the last strobe.
- Gapped valid:
  - Stimulus: same frame with `s_valid` low for random 0–5 cycles between bytes.
  - Required: identical write sequence; each strobe is 1 cycle after its 4th byte.
- Zero counts:
  - Stimulus: header `00 00 00 00`.
  - Required: no write strobes; `d_bram_init_done` and `cpu_run` both high 1 cycle after the 4th byte.
- Overflow:
  - Stimulus: header `01 01 01 00` (`d_cnt` = 257).
  - Required: `err = 1`, `s_ready = 0`, no strobes, `cpu_run = 0`. A subsequent `start` plus a valid frame completes normally.
- Reset mid-word:
  - Stimulus: drop `rst` after 2 bytes of data word 1.
  - Required: all outputs 0 and state IDLE. After `start`, a fresh frame reloads from address 0.
- Re-load:
  - Stimulus: `start` in DONE.
  - Required: `cpu_run` and `d_bram_init_done` fall on the next edge; `s_ready` rises.
